barrel_shifter_pipe: RTL
========================

// Module: barrel_shifter_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter with valid/ready handshakes on input and output.
//   Supports logical, arithmetic and rotate operations in both directions, and reports the last bit shifted out.
//   It is the streaming successor to the 8-bit combinational shifter, for use in datapaths that need one shift per clock.
// PARAMETERS
//   WIDTH      8   data width; power of two, >= 2; SHW = $clog2(WIDTH)
//   PIPELINED  1   1: one register stage per shift level (latency SHW); 0: single output register (latency 1)
// PORTS
//   clk        in   1      clock; all logic on posedge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      shifter can accept a beat this cycle
//   in_data    in   WIDTH  operand
//   in_n       in   SHW    shift amount, 0..WIDTH-1
//   in_lr      in   1      direction: 1 = left, 0 = right
//   in_op      in   2      00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  shifted result
//   out_carry  out  1      last bit shifted out; 0 when in_n = 0
// BEHAVIOUR
//   - Reset (rst_n = 0 at posedge): out_valid = 0, out_data = 0, out_carry = 0, all stage valids = 0.
//     In-flight beats are discarded. in_ready = 1 in the first cycle after reset.
//   - Transfer rules:
//     - Input transfers when in_valid && in_ready.
//     - Output transfers when out_valid && out_ready.
//     - out_data and out_carry are held stable while out_valid && !out_ready.
//   - Global enable en = !out_valid || out_ready. in_ready = en (combinational).
//     When en = 0, every stage holds its data and its valid.
//     When en = 1, every stage advances; bubbles (valid = 0) advance too.
//   - Latency:
//     - PIPELINED = 1: SHW cycles from input transfer to out_valid.
//     - PIPELINED = 0: 1 cycle.
//     - Throughput: one beat per cycle when out_ready is held at 1.
//   - Stage k (k = 0..SHW-1) applies a shift of 2^k when in_n[k] = 1, otherwise passes data through.
//     in_n, in_lr and in_op travel with the data.
//   - Operations:
//     - Logical left/right: vacated bits are 0.
//     - Arithmetic right: vacated bits are copies of in_data[WIDTH-1]. Arithmetic left is the same as logical left.
//     - Rotate left/right: bits shifted out re-enter at the opposite end.
//   - Carry is computed at input from the original operand and carried with the beat:
//     - left:  in_data[WIDTH-in_n]
//     - right: in_data[in_n-1]
//     - in_n = 0: carry is 0 for all ops.
//     - Rotate carry follows the same rule: the last bit that wrapped round.
//   - in_n = 0: out_data = in_data for every op.
//   - Reserved op 11 behaves as 00; no error flag.
//   - Simultaneous output transfer and input transfer in the same cycle is legal with no bubble.
//   - Reset overrides en.
// TESTING  (WIDTH = 8, in_data = 8'b11011001 unless stated)
//   1. lr=1, op=00, n=3 -> out_data 8'b11001000, carry 0.
//      lr=0, op=00, n=4 -> out_data 8'b00001101, carry 1.
//   2. lr=0, op=01, n=5 -> out_data 8'b11111110, carry 1.
//      lr=1, op=10, n=7 -> out_data 8'b11101100, carry 0.
//      lr=0, op=10, n=1 -> out_data 8'b11101100, carry 1.
//   3. Back-to-back beats n = 0..7, out_ready = 1 ->
//      - out_valid goes high SHW (3) cycles after the first beat, then stays high for 8 consecutive cycles;
//      - results are in order;
//      - n = 0 results equal the input with carry 0.
//   4. Hold out_ready = 0 while streaming ->
//      - in_ready drops once out_valid = 1;
//      - out_data is stable until out_ready;
//      - no beats are lost or duplicated after release (scoreboard).
//   5. Assert rst_n = 0 for 1 cycle with 2 beats in flight ->
//      - out_valid = 0 and out_data = 0 next cycle;
//      - the flushed beats never appear.
//   6. PIPELINED = 0, WIDTH = 16, random ops/n/data with random out_ready ->
//      - latency is 1 cycle;
//      - all results match a reference model.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one shift level per stage, valid/ready on both sides.
// Carry is resolved at entry from the original operand and rides with the beat.
module barrel_shifter_pipe #(
    parameter int WIDTH     = 8,
    parameter bit PIPELINED = 1'b1,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_n,
    input  logic             in_lr,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    function automatic logic [WIDTH-1:0] lvl(
        input logic [WIDTH-1:0] d,
        input int               s,
        input logic             lr,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        if (op == 2'b10) begin
            r = lr ? ((d << s) | (d >> (WIDTH - s)))
                   : ((d >> s) | (d << (WIDTH - s)));
        end else if (lr) begin
            r = d << s;
        end else if (op == 2'b01) begin
            // MSB is still the original sign at every level
            r = (d >> s) | (~({WIDTH{1'b1}} >> s) & {WIDTH{d[WIDTH-1]}});
        end else begin
            r = d >> s;
        end
        return r;
    endfunction

    logic           en;
    logic [SHW-1:0] cidx;
    logic           cin;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // left: bit WIDTH-n (== -n mod WIDTH); right: bit n-1
    assign cidx = in_lr ? (~in_n + SHW'(1)) : (in_n - SHW'(1));
    assign cin  = (in_n != '0) && in_data[cidx];

    logic [WIDTH-1:0] sd  [SHW+1];
    logic [SHW-1:0]   sn  [SHW+1];
    logic             slr [SHW+1];
    logic [1:0]       sop [SHW+1];
    logic             sc  [SHW+1];
    logic             sv  [SHW+1];

    assign sd[0]  = in_data;
    assign sn[0]  = in_n;
    assign slr[0] = in_lr;
    assign sop[0] = in_op;
    assign sc[0]  = cin;
    assign sv[0]  = in_valid;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] nd;

        assign nd = sn[k][k] ? lvl(sd[k], 2 ** k, slr[k], sop[k])
                             : sd[k];

        if (PIPELINED || k == SHW - 1) begin : g_reg
            logic [WIDTH-1:0] q_d;
            logic [SHW-1:0]   q_n;
            logic             q_lr;
            logic [1:0]       q_op;
            logic             q_c;
            logic             q_v;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_d  <= '0;
                    q_n  <= '0;
                    q_lr <= 1'b0;
                    q_op <= 2'b00;
                    q_c  <= 1'b0;
                    q_v  <= 1'b0;
                end else if (en) begin
                    q_d  <= nd;
                    q_n  <= sn[k];
                    q_lr <= slr[k];
                    q_op <= sop[k];
                    q_c  <= sc[k];
                    q_v  <= sv[k];
                end
            end

            assign sd[k+1]  = q_d;
            assign sn[k+1]  = q_n;
            assign slr[k+1] = q_lr;
            assign sop[k+1] = q_op;
            assign sc[k+1]  = q_c;
            assign sv[k+1]  = q_v;
        end else begin : g_comb
            assign sd[k+1]  = nd;
            assign sn[k+1]  = sn[k];
            assign slr[k+1] = slr[k];
            assign sop[k+1] = sop[k];
            assign sc[k+1]  = sc[k];
            assign sv[k+1]  = sv[k];
        end
    end

    assign out_data  = sd[SHW];
    assign out_carry = sc[SHW];
    assign out_valid = sv[SHW];

endmodule
